// File: rtl/fm0_pkg.sv
// Shared types, CRC constants and helpers for the FM0 frame decoder.
package fm0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_SECOND
  } state_t;

  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

  function automatic int sps_of_bank(input int base, input int step, input int bank);
    return base + bank * step;
  endfunction

  // One MSB-first shift of the Gen2 CRC-16 register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 (poly 0x1021), preset on init, one shift per enabled cycle.
module crc16_serial
  import fm0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC_PRESET;
    end else if (init) begin
      crc <= CRC_PRESET;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/fm0_frame_decoder.sv
// FM0 half-symbol integrator and bit decoder with frame counting, CRC-16 residue
// check, boundary-violation detection and inter-sample timeout.
module fm0_frame_decoder
  import fm0_pkg::*;
#(
  parameter int BANKS      = 4,
  parameter int BANK_WIDTH = $clog2(BANKS),
  parameter int SPS_BASE   = 8,
  parameter int SPS_STEP   = 4,
  parameter int FRAME_BITS = 128,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_dat,
  input  logic                  in_vld,
  input  logic [BANK_WIDTH-1:0] frequency_bank,
  input  logic                  preamble_detected,
  output logic                  bit_dat,
  output logic                  bit_vld,
  output logic                  frame_done,
  output logic                  crc_ok,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int HALF_MAX = sps_of_bank(SPS_BASE, SPS_STEP, BANKS - 1) / 2;
  localparam int CNT_W    = $clog2(HALF_MAX + 1);
  localparam int BIT_W    = $clog2(FRAME_BITS + 1);
  localparam int TO_W     = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   half_len;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   ones_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [TO_W-1:0]    idle_cnt;
  logic               first_lvl;
  logic               prev_lvl;
  logic               first_sym;
  logic [15:0]        crc;
  logic [15:0]        crc_next;

  logic               active;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   ones_inc;
  logic               half_end;
  logic               half_lvl;
  logic               sym_bit;
  logic               boundary_bad;
  logic               timeout_hit;
  logic               abort;
  logic               emit;
  logic               last_bit;

  always_comb begin
    active       = (state != ST_IDLE);
    cnt_inc      = sample_cnt + 1'b1;
    ones_inc     = ones_cnt + CNT_W'(in_dat);
    half_end     = active && in_vld && (cnt_inc == half_len);
    // Majority vote over the half-symbol; a tie counts as low.
    half_lvl     = ({ones_inc, 1'b0} > {1'b0, half_len});
    sym_bit      = (first_lvl == half_lvl);
    boundary_bad = !first_sym && (first_lvl == prev_lvl);
    timeout_hit  = active && !in_vld && (idle_cnt == TO_W'(TIMEOUT - 1));
    abort        = timeout_hit || (half_end && (state == ST_SECOND) && boundary_bad);
    emit         = !preamble_detected && half_end && (state == ST_SECOND) && !boundary_bad;
    last_bit     = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    crc_next     = crc16_step(crc, sym_bit);
  end

  crc16_serial u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (preamble_detected),
    .en   (emit),
    .din  (sym_bit),
    .crc  (crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      half_len   <= '0;
      sample_cnt <= '0;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      first_lvl  <= 1'b0;
      prev_lvl   <= 1'b0;
      first_sym  <= 1'b0;
      bit_dat    <= 1'b0;
      bit_vld    <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      bit_vld    <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      frame_err  <= 1'b0;
      // A new preamble wins over anything the current frame would do this cycle.
      if (preamble_detected) begin
        half_len   <= CNT_W'(sps_of_bank(SPS_BASE, SPS_STEP, int'(frequency_bank)) / 2);
        state      <= ST_FIRST;
        sample_cnt <= '0;
        ones_cnt   <= '0;
        bit_cnt    <= '0;
        idle_cnt   <= '0;
        prev_lvl   <= 1'b0;
        first_sym  <= 1'b1;
        busy       <= 1'b1;
      end else if (abort) begin
        frame_done <= 1'b1;
        frame_err  <= 1'b1;
        busy       <= 1'b0;
        state      <= ST_IDLE;
      end else if (active && in_vld) begin
        idle_cnt <= '0;
        if (!half_end) begin
          sample_cnt <= cnt_inc;
          ones_cnt   <= ones_inc;
        end else begin
          sample_cnt <= '0;
          ones_cnt   <= '0;
          if (state == ST_FIRST) begin
            first_lvl <= half_lvl;
            state     <= ST_SECOND;
          end else begin
            bit_vld   <= 1'b1;
            bit_dat   <= sym_bit;
            prev_lvl  <= half_lvl;
            first_sym <= 1'b0;
            bit_cnt   <= bit_cnt + 1'b1;
            if (last_bit) begin
              frame_done <= 1'b1;
              crc_ok     <= (crc_next == CRC_RESIDUE);
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              state <= ST_FIRST;
            end
          end
        end
      end else if (active) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/fm0_frame_decoder.md
# fm0_frame_decoder

Consumes the aligned, oversampled 1-bit tag-reply stream emitted after preamble detection and decodes it into FM0 data bits. Symbol length comes from the frequency bank latched at the start-of-frame pulse. Decoded bits go out one at a time, and the block counts a fixed-length frame, checks its Gen2 CRC-16, and reports frame completion or error. It sits directly downstream of the preamble detector, ahead of the packet/EPC handling logic.

## Interface
- `BANKS`, 4: number of frequency banks; `BANK_WIDTH = $clog2(BANKS)`.
- `SPS_BASE`, 8: samples per symbol for bank 0; must be even and ≥ 4.
- `SPS_STEP`, 4: extra samples per symbol per bank index; must be even.
- `FRAME_BITS`, 128: decoded bits per frame, including the trailing 16 CRC bits; must be ≥ 17.
- `TIMEOUT`, 1024: max clocks between `in_vld` pulses while a frame is in progress.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_dat` in 1: sample value.
- `in_vld` in 1: sample strobe.
- `frequency_bank` in BANK_WIDTH: bank index; sampled only on `preamble_detected`.
- `preamble_detected` in 1: one-cycle start-of-frame pulse.
- `bit_dat` out 1: decoded bit.
- `bit_vld` out 1: one-cycle strobe for `bit_dat`.
- `frame_done` out 1: one-cycle end-of-frame pulse (good or bad).
- `crc_ok` out 1: valid with `frame_done`; 1 only if the frame completed and the CRC residue matched.
- `frame_err` out 1: valid with `frame_done`; 1 on FM0 violation or timeout.
- `busy` out 1: high while a frame is in progress.

## Operation
- Samples per symbol: `sps = SPS_BASE + bank*SPS_STEP`, latched on `preamble_detected`. Half-symbol length is `h = sps/2`.
- Counter width is sized for the largest bank.
- States:
  - IDLE: waits for `preamble_detected`.
  - FIRST: accumulates the first half-symbol.
  - SECOND: accumulates the second half-symbol.
- FSM transitions:
  - IDLE → FIRST on `preamble_detected`. This clears the sample counter, ones counter, bit count, CRC (preset 0xFFFF) and the previous-level flag; the latter marks the first symbol.
  - FIRST → SECOND after `h` valid samples.
  - SECOND → FIRST after `h` valid samples, when a bit is emitted.
  - Only `in_vld` cycles count as samples.
- Half level: 1 if `2*ones > h`, else 0. Ties resolve to 0.
- Bit decision at the end of each symbol:
  - Equal half levels → bit 1; unequal half levels → bit 0.
  - FM0 boundary rule: the first-half level must differ from the previous symbol's second-half level. The check is skipped for the first symbol after the pulse.
  - A boundary failure is a violation: pulse `frame_done` with `frame_err=1`, `crc_ok=0`, emit no bit, go to IDLE.
- Every emitted bit is shifted into the serial CRC-16 (poly 0x1021, MSB-first).
- After bit number `FRAME_BITS` is emitted, check the residue: `crc_ok = (crc == 16'h1D0F)`, `frame_err=0`, pulse `frame_done`, go to IDLE.
- Timeout:
  - An idle counter resets on every `in_vld` while in FIRST/SECOND.
  - On reaching `TIMEOUT`, abort exactly like a violation.
- `preamble_detected` while busy restarts the frame: new bank latched, all state cleared, no `frame_done` for the aborted frame. This takes priority over any same-cycle symbol completion, violation or timeout.
- Samples in IDLE are ignored.

## Timing
- Reset values: all outputs and counters 0, state IDLE.
- Async assert; deassert is synchronised externally.
- `bit_vld`/`bit_dat` are registered and assert the cycle after the `in_vld` that completes the symbol.
- The last bit's `bit_vld` and `frame_done` assert in the same cycle.
- A violation or timeout `frame_done` asserts the cycle after detection.
- `busy` rises the cycle after `preamble_detected` and falls in the same cycle `frame_done` is high.
- A `preamble_detected` in the same cycle as the final `frame_done` is accepted: the new frame starts.

## Structure
- Shared package `fm0_pkg`:
  - state enum;
  - CRC_POLY 0x1021, CRC_PRESET 0xFFFF, CRC_RESIDUE 0x1D0F;
  - function `sps_of_bank`.
- Sub-module `crc16_serial`: `clk`, `rst`, `init`, `en`, `din`, `crc[15:0]`.
- Everything else (FSM, counters, timeout) lives in `fm0_frame_decoder`.

## Test plan
- Reset: assert `rst` low mid-stream → all outputs 0, `busy=0`; no `bit_vld` until the next `preamble_detected`.
- Bank 0 (sps 8): pulse, then samples 00001111, 00000000 → `bit_vld` twice with `bit_dat` 0 then 1, `busy=1`.
- Violation, bank 0: 11110000 followed by 00001111 (second half 0 then first half 0) → after the second symbol, `frame_done=1`, `frame_err=1`, `crc_ok=0`, no second `bit_vld`, `busy=0`.
- Full frame, `FRAME_BITS=32`, bank 1 (sps 12): 16-bit payload 0xA5C3 followed by the ones-complement of its CRC-16 (preset 0xFFFF, poly 0x1021) → 32 `bit_vld`, then `frame_done`, `crc_ok=1`, `frame_err=0`. Repeat with one payload bit flipped → `crc_ok=0`, `frame_err=0`.
- Timeout, `TIMEOUT=16`: stop `in_vld` for 16 clocks mid-symbol → `frame_done`, `frame_err=1`.
- Restart: `preamble_detected` with bank 2 after 5 bits of a bank-0 frame → no `frame_done`; the next symbols decode at sps 16.
